// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM block.
// Duty-select encoding and threshold computation.
package pwm_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_25  = 2'b00;
    localparam sel_t SEL_50  = 2'b01;
    localparam sel_t SEL_75  = 2'b10;
    localparam sel_t SEL_100 = 2'b11;

    // Number of high clocks per period for a given select.
    function automatic int unsigned thr(
        input sel_t        sel,
        input int unsigned period
    );
        return (int'(sel) + 1) * period / 4;
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Control/output bundle of the PWM block.
// Master drives enable and duty select; slave drives the pin.
interface pwm_if;

    logic E;
    logic X;
    logic Y;
    logic Out;

    modport master (
        output E,
        output X,
        output Y,
        input  Out
    );

    modport slave (
        input  E,
        input  X,
        input  Y,
        output Out
    );

endinterface

// File: rtl/pwm_counter.sv
// Modulo-PERIOD counter with enable and synchronous clear.
// wrap flags the last count of the period.
module pwm_counter #(
    parameter int PERIOD = 8,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign wrap = (cnt_q == CNT_W'(PERIOD - 1));

    // Next count: clear wins, otherwise advance and roll over at the period end.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm.sv
// Fixed-period PWM with 2-bit duty select.
// Select is latched only at period boundaries, so no runt pulses.
module pwm
    import pwm_pkg::*;
#(
    parameter int PERIOD = 8,
    parameter int CNT_W  = 3
) (
    input  logic Clk,
    input  logic reset,
    pwm_if.slave bus
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic [CNT_W:0]   thr_v;

    sel_t sel_q;
    sel_t sel_d;
    logic out_q;
    logic out_d;

    pwm_counter #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_counter (
        .clk   (Clk),
        .reset (reset),
        .en    (bus.E),
        .clr   (!bus.E),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign bus.Out = out_q;

    // Compare the current count against the latched duty threshold.
    always_comb begin
        thr_v = (CNT_W + 1)'(thr(sel_q, PERIOD));
        sel_d = sel_q;
        out_d = 1'b0;
        if (!bus.E) begin
            sel_d = {bus.X, bus.Y};
        end else begin
            out_d = ({1'b0, cnt} < thr_v);
            if (wrap) begin
                sel_d = {bus.X, bus.Y};
            end
        end
    end

    // Select latch and registered output pin.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sel_q <= SEL_25;
            out_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_pwm.sv
// Scoreboard bench for pwm at PERIOD 4, 8 and 16.
// A per-instance reference model queues expected Out values.
module tb_pwm;

    logic Clk   = 1'b0;
    logic reset = 1'b0;
    logic E     = 1'b0;
    logic X     = 1'b0;
    logic Y     = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    function automatic void check(
        input int    p,
        input string name,
        input logic  act,
        input logic  exp
    );
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s P=%0d: Out=%b expected %b at %0t",
                     name, p, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int P = 4 << g;
        localparam int W = 2 + g;

        pwm_if u_if ();

        assign u_if.E = E;
        assign u_if.X = X;
        assign u_if.Y = Y;

        pwm #(
            .PERIOD (P),
            .CNT_W  (W)
        ) u_dut (
            .Clk   (Clk),
            .reset (reset),
            .bus   (u_if.slave)
        );

        bit       exp_q[$];
        int       n;
        bit [1:0] sel;

        // Reference: n counts enabled edges; period index is n / P.
        always @(posedge Clk or negedge reset) begin
            if (!reset) begin
                n   = 0;
                sel = 2'b00;
                exp_q.delete();
            end else if (!E) begin
                n   = 0;
                sel = {X, Y};
                exp_q.push_back(1'b0);
            end else begin
                exp_q.push_back((n % P) < (int'(sel) + 1) * P / 4);
                if (n % P == P - 1) begin
                    sel = {X, Y};
                end
                n++;
            end
        end

        // Monitor: compare on the falling edge, away from updates.
        always @(negedge Clk) begin
            bit e;
            if (!reset) begin
                check(P, "reset_hold", u_if.Out, 1'b0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(P, "duty", u_if.Out, e);
            end
        end

        // Output must drop without waiting for a clock edge.
        always @(negedge reset) begin
            #1;
            check(P, "async_reset", u_if.Out, 1'b0);
        end
    end

    task automatic step(input int cycles);
        repeat (cycles) @(posedge Clk);
        #2;
    endtask

    task automatic set_sel(input bit [1:0] s);
        {X, Y} = s;
    endtask

    initial begin
        reset = 1'b0;
        E     = 1'b1;
        set_sel(2'b00);
        step(5);
        #1 reset = 1'b1;

        step(48);
        for (int s = 1; s < 4; s++) begin
            set_sel(2'(s));
            step(40);
        end

        set_sel(2'b00);
        step(35);
        step(3);
        set_sel(2'b10);
        step(40);

        set_sel(2'b01);
        step(17);
        E = 1'b0;
        step(3);
        E = 1'b1;
        step(20);

        for (int i = 0; i < 800; i++) begin
            E = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) begin
                set_sel(2'($urandom_range(0, 3)));
            end
            step(1);
        end

        E = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step($urandom_range(3, 30));
            #1 reset = 1'b0;
            step(2);
            #1 reset = 1'b1;
        end

        set_sel(2'b11);
        step(40);

        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm.md
# pwm

Fixed-period pulse-width modulator producing one digital output whose duty cycle is selected by two control bits, X and Y. The block sits at the edge of the design and drives a single PWM pin, for example an LED or a motor gate. It has an enable input and returns to a known low state under reset or when disabled.

## Interface
- PERIOD, default 8: PWM period in clocks; must be a multiple of 4 and at least 4.
- CNT_W, default 3: counter width; must satisfy 2^CNT_W >= PERIOD.
- Clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset; one clock; reset is asynchronous and active-low (reset=0 clears all state immediately).
- E  in  1  enable; 1 = run, 0 = stop with Out low.
- X  in  1  duty select, MSB.
- Y  in  1  duty select, LSB.
- Out  out  1  registered PWM output.

## Operation
- Internal state:
  - period counter cnt[CNT_W-1:0].
  - latched select sel_q[1:0].
  - output register Out.
- Duty encoding, with sel = {X,Y}: threshold thr(sel) = (sel+1)*PERIOD/4.
  - 00 = 25%, 01 = 50%, 10 = 75%, 11 = 100% (constant high).
- Reset (reset=0, asynchronous): cnt=0, sel_q=00, Out=0.
- Rising edge with E=0:
  - cnt<=0.
  - Out<=0.
  - sel_q<={X,Y}, so the first enabled period uses the current selection.
- Rising edge with E=1:
  - Out <= (cnt < thr(sel_q)).
  - cnt <= (cnt==PERIOD-1) ? 0 : cnt+1.
  - If cnt==PERIOD-1, sel_q<={X,Y}; the new duty takes effect from the next period.
- X/Y changes mid-period never affect the current period, so there are no runt or glitch pulses.
- Period boundary is defined by the counter only; no other event restarts it while E=1.

## Timing
- Output latency: Out reflects the cnt value one clock earlier (registered, no combinational path from any input to Out).
- First enabled period starts at the first rising edge with E=1 after E=0 or reset release.
  - Out rises at that edge for sel<11 and sel=11 alike (thr ≥ PERIOD/4 ≥ 1).
- High time per period = thr(sel_q) clocks; low time = PERIOD − thr clocks. With PERIOD=8:
  - 00 gives 2 high / 6 low.
  - 01 gives 4 / 4.
  - 10 gives 6 / 2.
  - 11 gives 8 / 0.
- E falling: at the next edge Out=0 and cnt=0; the partial period is discarded.
- Reset asserted mid-period: Out goes 0 asynchronously and cnt=0.
  - After release, operation resumes as a fresh start if E=1.
- Select change exactly at the edge where cnt==PERIOD-1: the new value is captured and used for the following period.
- Inputs are treated as synchronous to Clk; no internal synchronizers.

## Structure
- Shared package pwm_pkg:
  - 2-bit select typedef.
  - constants SEL_25=2'b00, SEL_50=2'b01, SEL_75=2'b10, SEL_100=2'b11.
  - threshold function thr(sel, PERIOD).
- Optional sub-module pwm_counter: modulo-PERIOD counter with enable and clear, exposing a wrap flag (cnt==PERIOD-1).
- Top level holds sel_q, the comparator and the Out register.

## Test plan
- Reset: hold reset=0 with E=1 → Out=0, cnt=0 throughout. Assert reset mid-period → Out drops to 0 without waiting for a clock edge.
- X=0, Y=0, E=1 after reset release (PERIOD=8) → Out high 2 clocks then low 6, repeating. Check 3 periods.
- {X,Y}=01, 10 and 11 → 4/4, 6/2 and constant high respectively. Out never falls for 11.
- Change {X,Y} from 00 to 10 mid-period → current period keeps 2 high; next period shows 6 high.
- Drop E to 0 during the high phase → Out=0 at the next edge. Re-raise E → a new period starts with Out high on the first enabled edge.
- Parameter sweep PERIOD=4 and 16 → high clocks equal (sel+1)*PERIOD/4 for all four selects.
